// File: rtl/sts_evt_pkg.sv
// sts_evt_pkg: flag index map, event word layout and FSM state type for sts_evt_reporter.
package sts_evt_pkg;
    localparam int FLAG_W_DEF = 147;
    localparam int FLAG_IDX_SPI_OFF = 0;
    localparam int FLAG_IDX_OVER_THRESH = 1;
    localparam int FLAG_IDX_OVER_THRESH_N = 8;
    localparam int FLAG_IDX_SPI_CRC_ERR = 9;
    localparam int FLAG_IDX_SPI_FRAME_ERR = 10;
    localparam int FLAG_IDX_ADC_DLY_SHORT = 146;
    localparam int EVT_IDX_LSB = 0;
    localparam int EVT_IDX_W = 8;
    localparam int EVT_TS_LSB = 8;
    localparam int EVT_TS_W = 24;
    typedef enum logic {EMPTY, FULL} state_t;
endpackage

// File: rtl/sts_prio_enc.sv
// sts_prio_enc: lowest-set-bit encoder; idx is the lowest set position, any flags a non-zero input.
module sts_prio_enc #(
    parameter int W = 147
) (
    input  logic [W-1:0] req,
    output logic [7:0]   idx,
    output logic         any
);
    always_comb begin
        idx = '0;
        any = |req;
        for (int i = W - 1; i >= 0; i--)
            if (req[i]) idx = 8'(i);
    end
endmodule

// File: rtl/sts_evt_reporter.sv
// sts_evt_reporter: rising-edge detect, sticky bits and serialized event words for status flags.
// Define STS_EVT_TIMESTAMP_EN to stamp each word with a 24-bit free-running cycle counter.
module sts_evt_reporter
    import sts_evt_pkg::*;
#(
    parameter int FLAG_W = FLAG_W_DEF,
    parameter int LOST_W = 8
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [FLAG_W-1:0] sts_flags,
    input  logic              sts_clear,
    output logic [FLAG_W-1:0] sts_sticky,
    output logic [31:0]       evt_tdata,
    output logic              evt_tvalid,
    input  logic              evt_tready,
    output logic [LOST_W-1:0] evt_lost,
    output logic              irq
);
    logic [FLAG_W-1:0] flags_q, pending, rise, load_mask;
    logic [7:0] pend_idx;
    logic [EVT_TS_W-1:0] ts;
    logic pend_any, load, lost_inc;
    state_t state_q, state_d;

    sts_prio_enc #(.W(FLAG_W)) u_enc (.req(pending), .idx(pend_idx), .any(pend_any));

    assign rise = sts_flags & ~flags_q;
    assign evt_tvalid = state_q == FULL;

    always_comb begin
        load = pend_any && (state_q == EMPTY || evt_tready);
        load_mask = load ? FLAG_W'(1) << pend_idx : '0;
        // a re-rise of the index being loaded this cycle simply re-arms it, so it is not a loss
        lost_inc = |(rise & pending & ~load_mask);
        state_d = load ? FULL : (state_q == FULL && evt_tready) ? EMPTY : state_q;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= EMPTY;
            flags_q <= '0;
            pending <= '0;
            sts_sticky <= '0;
            evt_lost <= '0;
            evt_tdata <= '0;
            irq <= 1'b0;
        end else begin
            state_q <= state_d;
            flags_q <= sts_flags;
            pending <= (pending & ~load_mask) | rise;
            sts_sticky <= (sts_clear ? '0 : sts_sticky) | rise;
            evt_lost <= sts_clear ? '0 : evt_lost + LOST_W'(lost_inc && !(&evt_lost));
            irq <= |sts_sticky;
            if (load) evt_tdata <= {ts, pend_idx};
        end
    end

`ifdef STS_EVT_TIMESTAMP_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) ts <= '0;
        else ts <= ts + 1'b1;
    end
`else
    assign ts = '0;
`endif
endmodule

// File: tb/tb_sts_evt_reporter.sv
// tb_sts_evt_reporter: randomized and directed checks of sts_evt_reporter against a cycle-level reference model.
module tb_sts_evt_reporter;
    localparam int FW = 147;
    localparam int OW = 1 + 32 + 8 + 1 + FW;

    logic aclk = 0, aresetn = 1, sts_clear = 0, evt_tready = 0;
    logic [FW-1:0] sts_flags = '0;
    logic [FW-1:0] sts_sticky;
    logic [31:0] evt_tdata;
    logic [7:0] evt_lost;
    logic evt_tvalid, irq;
    logic [OW-1:0] obs;

    int checks = 0, errors = 0;

    logic [FW-1:0] m_fq, m_pend, m_sticky;
    logic m_valid, m_irq;
    logic [31:0] m_data;
    int m_lost, m_ts;

    sts_evt_reporter dut (
        .aclk(aclk), .aresetn(aresetn), .sts_flags(sts_flags), .sts_clear(sts_clear),
        .sts_sticky(sts_sticky), .evt_tdata(evt_tdata), .evt_tvalid(evt_tvalid),
        .evt_tready(evt_tready), .evt_lost(evt_lost), .irq(irq)
    );

    always #5 aclk = ~aclk;

    assign obs = {evt_tvalid, evt_tdata, evt_lost, irq, sts_sticky};

    function automatic logic [OW-1:0] exp_v();
        return {m_valid, m_data, 8'(m_lost), m_irq, m_sticky};
    endfunction

    task automatic m_reset();
        m_fq = '0; m_pend = '0; m_sticky = '0; m_valid = 0; m_irq = 0;
        m_data = '0; m_lost = 0; m_ts = 0;
    endtask

    // One clock edge; the model applies the event-reporter rules to the inputs seen at that edge.
    task automatic step();
        logic [FW-1:0] rise;
        logic [23:0] ts24;
        int idx;
        bit load, lostf;
        @(posedge aclk);
        rise = sts_flags & ~m_fq;
        idx = -1;
        lostf = 0;
        for (int i = FW - 1; i >= 0; i--) if (m_pend[i]) idx = i;
        load = idx >= 0 && (!m_valid || evt_tready);
        for (int i = 0; i < FW; i++)
            if (rise[i] && m_pend[i] && !(load && i == idx)) lostf = 1;
`ifdef STS_EVT_TIMESTAMP_EN
        ts24 = m_ts[23:0];
`else
        ts24 = '0;
`endif
        m_irq = |m_sticky;
        m_sticky = (sts_clear ? '0 : m_sticky) | rise;
        m_lost = sts_clear ? 0 : (lostf && m_lost < 255) ? m_lost + 1 : m_lost;
        if (load) begin
            m_pend[idx] = 0;
            m_data = {ts24, 8'(idx)};
            m_valid = 1;
        end else if (m_valid && evt_tready) m_valid = 0;
        m_pend = m_pend | rise;
        m_fq = sts_flags;
        m_ts = (m_ts + 1) & 32'hFFFFFF;
        #1;
    endtask

    task automatic test_reset();
        m_reset();
        #1 aresetn = 0;
        #19;
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL reset_state got %h exp 0", obs); end
        #1 aresetn = 1;
        for (int c = 0; c < 6; c++) begin
            step();
            checks++;
            if (obs !== exp_v()) begin errors++; $display("FAIL reset_idle got %h exp %h", obs, exp_v()); end
            checks++;
            if (evt_tvalid !== 0 || irq !== 0) begin errors++; $display("FAIL reset_quiet got v=%b irq=%b exp 0 0", evt_tvalid, irq); end
        end
    endtask

    task automatic test_single();
        int first = -1;
        evt_tready = 1;
        sts_flags[5] = 1;
        step();
        sts_flags[5] = 0;
        for (int c = 1; c <= 4; c++) begin
            step();
            checks++;
            if (obs !== exp_v()) begin errors++; $display("FAIL single got %h exp %h", obs, exp_v()); end
            if (evt_tvalid && first < 0) begin
                first = c;
                checks++;
                if (evt_tdata[7:0] !== 8'h05) begin errors++; $display("FAIL single_idx got %h exp 05", evt_tdata[7:0]); end
            end
        end
        checks++;
        if (first != 1) begin errors++; $display("FAIL single_latency got %0d exp 1", first); end
        checks++;
        if (sts_sticky[5] !== 1 || irq !== 1) begin errors++; $display("FAIL single_sticky got %b/%b exp 1/1", sts_sticky[5], irq); end
        sts_clear = 1;
        step();
        sts_clear = 0;
        checks++;
        if (sts_sticky !== '0) begin errors++; $display("FAIL clear_sticky got %h exp 0", sts_sticky); end
        step();
        checks++;
        if (irq !== 0) begin errors++; $display("FAIL clear_irq got %b exp 0", irq); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        int c0 = -1, c1 = -1;
        evt_tready = 1;
        sts_flags[3] = 1; sts_flags[9] = 1; sts_flags[40] = 1;
        step();
        sts_flags = '0;
        for (int c = 1; c <= 6; c++) begin
            step();
            checks++;
            if (obs !== exp_v()) begin errors++; $display("FAIL b2b got %h exp %h", obs, exp_v()); end
            if (evt_tvalid) begin
                q.push_back(evt_tdata[7:0]);
                if (c0 < 0) c0 = c;
                c1 = c;
            end
        end
        checks++;
        if (q.size() != 3 || q[0] !== 8'h03 || q[1] !== 8'h09 || q[2] !== 8'h28 || c1 - c0 != 2)
            begin errors++; $display("FAIL b2b_order got n=%0d span=%0d exp 03,09,28 span 2", q.size(), c1 - c0); end
    endtask

    task automatic test_lost();
        sts_clear = 1;
        step();
        sts_clear = 0;
        evt_tready = 0;
        for (int r = 0; r < 303; r++) begin
            sts_flags[2] = 1;
            step();
            sts_flags[2] = 0;
            step();
            checks++;
            if (obs !== exp_v()) begin errors++; $display("FAIL lost_seq got %h exp %h", obs, exp_v()); end
            if (r == 2) begin
                checks++;
                if (evt_lost !== 8'd1 || evt_tvalid !== 1 || evt_tdata[7:0] !== 8'h02)
                    begin errors++; $display("FAIL lost_one got lost=%0d v=%b idx=%h exp 1 1 02", evt_lost, evt_tvalid, evt_tdata[7:0]); end
            end
        end
        checks++;
        if (evt_lost !== 8'hFF) begin errors++; $display("FAIL lost_sat got %h exp ff", evt_lost); end
    endtask

    task automatic test_clear_coincident();
        sts_clear = 1;
        sts_flags[7] = 1;
        step();
        sts_clear = 0;
        checks++;
        if (sts_sticky[7] !== 1 || sts_sticky[2] !== 0 || evt_lost !== 0)
            begin errors++; $display("FAIL clear_rise got s7=%b s2=%b lost=%0d exp 1 0 0", sts_sticky[7], sts_sticky[2], evt_lost); end
        sts_flags[7] = 0;
        evt_tready = 1;
        for (int c = 0; c < 6; c++) begin
            step();
            checks++;
            if (obs !== exp_v()) begin errors++; $display("FAIL clear_drain got %h exp %h", obs, exp_v()); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < 3; k++)
                if ($urandom_range(3) == 0) sts_flags[$urandom_range(FW - 1)] ^= 1'b1;
            if ($urandom_range(99) == 0) sts_flags = {$urandom, $urandom, $urandom, $urandom, $urandom};
            evt_tready = $urandom_range(3) != 0;
            sts_clear = $urandom_range(40) == 0;
            step();
            checks++;
            if (obs !== exp_v()) begin errors++; $display("FAIL random c=%0d got %h exp %h", c, obs, exp_v()); end
        end
        sts_clear = 0;
    endtask

    task automatic test_async_reset();
        bit seen = 0;
        evt_tready = 0;
        sts_flags = '0;
        sts_flags[1] = 1; sts_flags[20] = 1; sts_flags[100] = 1;
        for (int c = 0; c < 3; c++) step();
        checks++;
        if (evt_tvalid !== 1) begin errors++; $display("FAIL arst_pre got %b exp 1", evt_tvalid); end
        #2 aresetn = 0;
        #1;
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL arst_zero got %h exp 0", obs); end
        sts_flags = '0;
        sts_flags[11] = 1;
        m_reset();
        #2 aresetn = 1;
        evt_tready = 1;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (obs !== exp_v()) begin errors++; $display("FAIL arst_after got %h exp %h", obs, exp_v()); end
            if (evt_tvalid) begin
                checks++;
                if (evt_tdata[7:0] !== 8'd11) begin errors++; $display("FAIL arst_stale got %h exp 0b", evt_tdata[7:0]); end
                seen = 1;
            end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL arst_boot got none exp word 0b"); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_lost();
        test_clear_coincident();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
